// File: rtl/measurement_sequencer.sv
// measurement_sequencer: gates one counter measurement per request, applies a RUN
// timeout and presents each result over a valid/ready handshake.
module measurement_sequencer #(
    parameter int DOWNCOUNT_WIDTH = 16,
    parameter int UPCOUNT_WIDTH   = 40,
    parameter int TIMEOUT_WIDTH   = 32
) (
    input  logic                       MAJOR_CLOCK,
    input  logic                       RESET_N,
    input  logic                       start,
    input  logic                       abort,
    input  logic [DOWNCOUNT_WIDTH-1:0] cfg_gate,
    input  logic [TIMEOUT_WIDTH-1:0]   cfg_timeout,
    input  logic                       cfg_continuous,
    output logic                       cnt_load,
    output logic [DOWNCOUNT_WIDTH-1:0] cnt_gate,
    output logic                       cnt_abort,
    input  logic                       cnt_done,
    input  logic [UPCOUNT_WIDTH-1:0]   cnt_value,
    output logic                       busy,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [UPCOUNT_WIDTH-1:0]   res_count,
    output logic [DOWNCOUNT_WIDTH-1:0] res_gate,
    output logic [7:0]                 res_seq,
    output logic                       res_timeout,
    output logic                       res_overflow
);
    localparam logic [2:0] IDLE = 3'd0, LOAD = 3'd1, SETTLE = 3'd2, RUN = 3'd3, CAPTURE = 3'd4, PRESENT = 3'd5;
    logic [2:0] state, state_nx;
    logic [TIMEOUT_WIDTH-1:0] timer, timeout;
    logic timeout_hit, accept, arm;
    assign timeout_hit = state == RUN && !cnt_done && timeout != '0 && timer == timeout;
    assign res_valid   = state == PRESENT && !abort;
    assign accept      = res_valid && res_ready;
    assign busy        = state != IDLE;
    assign cnt_load    = state == LOAD;
    assign cnt_abort   = (abort && (state == LOAD || state == SETTLE || state == RUN)) || timeout_hit;
    // Configuration is captured on entry to LOAD so cnt_gate is already valid alongside cnt_load.
    assign arm = (state == IDLE && start && cfg_gate != '0 && !abort) || (accept && cfg_continuous);
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = arm ? LOAD : IDLE;
            LOAD:    state_nx = SETTLE;
            SETTLE:  state_nx = RUN;
            RUN:     state_nx = (cnt_done || timeout_hit) ? CAPTURE : RUN;
            CAPTURE: state_nx = PRESENT;
            PRESENT: state_nx = accept ? (cfg_continuous ? LOAD : IDLE) : PRESENT;
            default: state_nx = IDLE;
        endcase
        if (abort && busy) state_nx = IDLE;
    end
    always_ff @(posedge MAJOR_CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state        <= IDLE;
            cnt_gate     <= '0;
            timer        <= '0;
            timeout      <= '0;
            res_count    <= '0;
            res_gate     <= '0;
            res_seq      <= '0;
            res_timeout  <= 1'b0;
            res_overflow <= 1'b0;
        end else begin
            state <= state_nx;
            if (arm) begin
                cnt_gate <= cfg_gate;
                timeout  <= cfg_timeout;
                timer    <= '0;
            end else if (state == RUN && timer != '1) begin
                timer <= timer + 1'b1;
            end
            if (state == RUN && state_nx == CAPTURE) res_timeout <= !cnt_done;
            if (state == CAPTURE) begin
                res_count    <= cnt_value;
                res_gate     <= cnt_gate;
                res_overflow <= &cnt_value;
            end
            if (accept) res_seq <= res_seq + 8'd1;
        end
    end
endmodule

// File: tb/tb_measurement_sequencer.sv
// tb_measurement_sequencer: randomized measurements checked against outcome arithmetic
// (done vs. timeout cycle, handshake order, sequence numbering).
module tb_measurement_sequencer;
    localparam int DW = 16, UW = 40, TW = 32;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n, start, abort, cfg_continuous, cnt_done, res_ready;
    logic [DW-1:0] cfg_gate, nxt_gate;
    logic [TW-1:0] cfg_timeout, nxt_to;
    logic [UW-1:0] cnt_value;
    logic cnt_load, cnt_abort, busy, res_valid, res_timeout, res_overflow;
    logic [DW-1:0] cnt_gate, res_gate;
    logic [UW-1:0] res_count;
    logic [7:0] res_seq, seq_exp;
    int n_cmp = 0, n_err = 0;

    measurement_sequencer #(.DOWNCOUNT_WIDTH(DW), .UPCOUNT_WIDTH(UW), .TIMEOUT_WIDTH(TW)) dut (
        .MAJOR_CLOCK(clk), .RESET_N(rst_n), .start(start), .abort(abort),
        .cfg_gate(cfg_gate), .cfg_timeout(cfg_timeout), .cfg_continuous(cfg_continuous),
        .cnt_load(cnt_load), .cnt_gate(cnt_gate), .cnt_abort(cnt_abort),
        .cnt_done(cnt_done), .cnt_value(cnt_value), .busy(busy),
        .res_valid(res_valid), .res_ready(res_ready), .res_count(res_count),
        .res_gate(res_gate), .res_seq(res_seq), .res_timeout(res_timeout),
        .res_overflow(res_overflow)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic sample;
        @(negedge clk);
    endtask

    task automatic adv;
        @(posedge clk);
        #1;
    endtask

    // One measurement: counter reports done on RUN cycle k (k large = never).
    task automatic measure(input logic [DW-1:0] gate, input logic [TW-1:0] to, input int k,
                           input logic [UW-1:0] val, input int abort_at, input int rd,
                           input bit cont, input bit from_idle, output bit chained);
        int e;
        bit tmo;
        chained = 1'b0;
        cfg_continuous = cont;
        cnt_value = val;
        if (from_idle) begin
            cfg_gate = gate; cfg_timeout = to; start = 1'b1;
            sample;
            check("idle_busy", busy, 0);
            adv;
        end
        start = 1'($urandom); cfg_gate = DW'($urandom); cfg_timeout = TW'($urandom);
        sample;
        check("load_pulse", cnt_load, 1);
        check("load_gate", cnt_gate, gate);
        check("load_busy", busy, 1);
        adv;
        cnt_done = 1'($urandom);
        sample;
        check("settle_load", cnt_load, 0);
        check("settle_abort", cnt_abort, 0);
        adv;
        e = (to != 0 && k > int'(to) + 1) ? int'(to) + 1 : k;
        tmo = k > e;
        for (int r = 1; r <= e; r++) begin
            cnt_done = r >= k; abort = r == abort_at; start = 1'($urandom);
            sample;
            check("run_cnt_abort", cnt_abort, (r == abort_at) || (r == e && tmo));
            check("run_valid", res_valid, 0);
            check("run_busy", busy, 1);
            adv;
            if (r == abort_at) begin
                abort = 1'b0; cnt_done = 1'b0; start = 1'b0;
                sample;
                check("abort_idle", busy, 0);
                check("abort_valid", res_valid, 0);
                check("abort_seq", res_seq, seq_exp);
                check("abort_single", cnt_abort, 0);
                adv;
                return;
            end
        end
        cnt_done = 1'b0;
        sample;
        check("capture_valid", res_valid, 0);
        check("capture_abort", cnt_abort, 0);
        adv;
        cnt_value = UW'({$urandom, $urandom});
        for (int s = 0; s <= rd; s++) begin
            res_ready = s == rd;
            cfg_gate = (s == rd) ? nxt_gate : DW'($urandom);
            cfg_timeout = (s == rd) ? nxt_to : TW'($urandom);
            sample;
            check("pres_valid", res_valid, 1);
            check("pres_count", res_count, val);
            check("pres_gate", res_gate, gate);
            check("pres_seq", res_seq, seq_exp);
            check("pres_timeout", res_timeout, tmo);
            check("pres_overflow", res_overflow, val == {UW{1'b1}});
            adv;
        end
        res_ready = 1'b0; start = 1'b0;
        seq_exp++;
        if (cont) begin
            chained = 1'b1;
            return;
        end
        sample;
        check("post_busy", busy, 0);
        check("post_valid", res_valid, 0);
        adv;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit ch;
        logic [DW-1:0] g;
        logic [TW-1:0] t;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; cfg_continuous = 1'b0; cnt_done = 1'b0;
        res_ready = 1'b0; cfg_gate = '0; cfg_timeout = '0; cnt_value = '0; seq_exp = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_valid", res_valid, 0);
        check("rst_seq", res_seq, 0);
        rst_n = 1'b1;
        nxt_gate = 16'd10; nxt_to = 0;
        measure(16'd10, 0, 10, 40'd1234, 0, 2, 1'b0, 1'b1, ch);
        measure(16'd33, 50, 1000, 40'd77, 0, 0, 1'b0, 1'b1, ch);
        cfg_gate = '0; start = 1'b1;
        sample;
        adv;
        start = 1'b0;
        sample;
        check("gate0_busy", busy, 0);
        check("gate0_load", cnt_load, 0);
        adv;
        measure(16'd9, 0, 20, 40'd5, 4, 0, 1'b0, 1'b1, ch);
        measure(16'd12, 5, 6, {UW{1'b1}}, 0, 1, 1'b0, 1'b1, ch);
        nxt_gate = 16'd21; nxt_to = 8;
        measure(16'd20, 0, 3, 40'd99, 0, 20, 1'b1, 1'b1, ch);
        g = nxt_gate; t = nxt_to;
        for (int i = 0; i < 400; i++) begin
            logic [DW-1:0] cg;
            logic [TW-1:0] ct;
            int k;
            cg = g; ct = t;
            k = ($urandom_range(0, 7) == 0) ? 1000 : int'($urandom_range(1, 25));
            if (ct == 0 && k == 1000) k = 25;
            g = DW'($urandom_range(1, 65535));
            t = ($urandom_range(0, 2) == 0) ? '0 : TW'($urandom_range(1, 20));
            nxt_gate = g; nxt_to = t;
            measure(cg, ct, k,
                    ($urandom_range(0, 7) == 0) ? {UW{1'b1}} : UW'({$urandom, $urandom}),
                    ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 30)) : 0,
                    int'($urandom_range(0, 3)), $urandom_range(0, 9) < 7, !ch, ch);
        end
        if (ch) begin
            cfg_continuous = 1'b0; abort = 1'b1;
            sample;
            adv;
            abort = 1'b0;
        end
        cfg_gate = 16'd7; cfg_timeout = 0; start = 1'b1;
        adv;
        start = 1'b0;
        repeat (5) adv;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_abort", cnt_abort, 0);
        check("arst_load", cnt_load, 0);
        check("arst_valid", res_valid, 0);
        check("arst_seq", res_seq, 0);
        check("arst_cnt_gate", cnt_gate, 0);
        check("arst_res", {res_count, res_gate, res_timeout, res_overflow}, 0);
        adv;
        rst_n = 1'b1;
        seq_exp = 8'd0;
        nxt_gate = 16'd1; nxt_to = 0;
        measure(16'd3, 4, 2, 40'd6, 0, 0, 1'b0, 1'b1, ch);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
